kyber_parse: RTL and testbench



---
 rtl/kyber_parse.sv | 157 +++++++++++++++
 tb/tb_kyber_parse.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_parse.sv
// kyber_parse: rejection-sampling stage behind the keccak squeeze FIFO.
// Pulls 64-bit words, slices the byte stream LSB-first into 12-bit candidates
// and emits the N_COEF candidates that are below Q, in order and with their
// indices, to the coefficient store.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse: clear buffer/counters, enter RUN
//   in_data, in_valid squeezed word from keccak (byte 0 in bits [7:0])
//   gimme             level request for another word
//   coef, coef_idx    accepted coefficient and its index
//   coef_valid        coef/coef_idx valid; held until coef_ready
//   coef_ready        downstream accepts coef this cycle
//   done              one-cycle pulse after the last coefficient is taken
//   overflow          sticky: a word arrived while the buffer had no room
//   fsm_state         current FSM state (0 IDLE, 1 RUN, 2 DONE)
//   reject_cnt        saturating count of rejected candidates
//                     (only with KYBER_PARSE_REJECT_CNT_EN defined)
//
// Handshakes: a coefficient transfers on a clock edge where coef_valid and
// coef_ready are both high; coef/coef_idx do not change while coef_valid is
// high and coef_ready is low. A word transfers on any edge with in_valid high
// in RUN; gimme is only advisory, so a word that finds no room is dropped and
// flags overflow.
module kyber_parse #(
  parameter int Q      = 3329,
  parameter int N_COEF = 256,
  parameter int BUF_W  = 192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        gimme,
  output logic [11:0] coef,
  output logic [7:0]  coef_idx,
  output logic        coef_valid,
  input  logic        coef_ready,
  output logic        done,
  output logic        overflow,
  output logic [1:0]  fsm_state
`ifdef KYBER_PARSE_REJECT_CNT_EN
  ,
  output logic [15:0] reject_cnt
`endif
);

  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int ISS_W = $clog2(N_COEF + 1);
  localparam logic [CNT_W-1:0] CAND_BITS = CNT_W'(12);
  localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(64);
  localparam logic [CNT_W-1:0] GIMME_MAX = CNT_W'(BUF_W - 128);
  localparam logic [CNT_W-1:0] ROOM_MAX  = CNT_W'(BUF_W - 64);
  localparam logic [ISS_W-1:0] ISS_FULL  = ISS_W'(N_COEF);
  localparam logic [7:0]       IDX_LAST  = 8'(N_COEF - 1);
  localparam logic [11:0]      Q_V       = 12'(Q);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_next;
  logic [BUF_W-1:0]   bit_buf, buf_ext, buf_next;
  logic [CNT_W-1:0]   cnt, cnt_ext, cnt_next;
  logic [ISS_W-1:0]   issued;
  logic [11:0]        cand;
  logic               hs, out_free, extract, accept, room, word_in, word_ovf, last_hs;

  assign fsm_state = state;
  assign done      = (state == DONE);
  assign hs        = coef_valid & coef_ready;
  assign out_free  = ~coef_valid | coef_ready;
  assign cand      = bit_buf[11:0];
  assign last_hs   = (state == RUN) & hs & (coef_idx == IDX_LAST);

  // Request while there is room for this word plus one already in flight.
  assign gimme = (state == RUN) & (cnt <= GIMME_MAX) & (issued != ISS_FULL);

  assign extract = (state == RUN) & (cnt >= CAND_BITS) & out_free & (issued != ISS_FULL);
  assign accept  = extract & (cand < Q_V);

  // Extraction sees the pre-append buffer; the new word lands above what remains.
  always_comb begin
    buf_ext  = bit_buf;
    cnt_ext  = cnt;
    buf_next = bit_buf;
    cnt_next = cnt;
    if (extract) begin
      buf_ext = bit_buf >> 12;
      cnt_ext = cnt - CAND_BITS;
    end
    room     = (cnt_ext <= ROOM_MAX);
    word_in  = (state == RUN) & in_valid & room;
    word_ovf = (state == RUN) & in_valid & ~room;
    buf_next = buf_ext;
    cnt_next = cnt_ext;
    if (word_in) begin
      buf_next = buf_ext | ({{(BUF_W-64){1'b0}}, in_data} << cnt_ext);
      cnt_next = cnt_ext + WORD_BITS;
    end
    // Leftover bits after the last coefficient are thrown away.
    if (state == DONE) begin
      buf_next = '0;
      cnt_next = '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = IDLE;
      RUN:     if (last_hs) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (start) state_next = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      bit_buf    <= '0;
      cnt        <= '0;
      issued     <= '0;
      coef       <= '0;
      coef_idx   <= '0;
      coef_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      bit_buf <= buf_next;
      cnt     <= cnt_next;
      if (word_ovf) overflow <= 1'b1;
      if (accept) begin
        coef       <= cand;
        coef_idx   <= 8'(issued);
        coef_valid <= 1'b1;
        issued     <= issued + 1'b1;
      end else if (hs) begin
        coef_valid <= 1'b0;
      end
    end
  end

`ifdef KYBER_PARSE_REJECT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || start) begin
      reject_cnt <= '0;
    end else if (extract && !accept && reject_cnt != 16'hFFFF) begin
      reject_cnt <= reject_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kyber_parse.sv
// Directed bench for kyber_parse. A byte-level Kyber Parse model fills a
// scoreboard of {coef_idx, coef} pairs as words are handed to the DUT; every
// coefficient handshake pops and compares one entry.
module tb_kyber_parse;
  localparam int Q      = 3329;
  localparam int N_COEF = 256;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, coef_ready;
  logic [63:0] in_data;
  logic        gimme, coef_valid, done, overflow;
  logic [11:0] coef;
  logic [7:0]  coef_idx;
  logic [1:0]  fsm_state;
`ifdef KYBER_PARSE_REJECT_CNT_EN
  logic [15:0] reject_cnt;
`endif

  kyber_parse dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .gimme      (gimme),
    .coef       (coef),
    .coef_idx   (coef_idx),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .done       (done),
    .overflow   (overflow),
    .fsm_state  (fsm_state)
`ifdef KYBER_PARSE_REJECT_CNT_EN
    ,
    .reject_cnt (reject_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  logic [19:0] exp_q[$];
  logic [7:0]  m_bytes[$];
  int          m_issued;
  int          n_hs, n_done, n_words, n_gtog;
  logic        seen_valid, g_prev;
  logic [19:0] cap0, cap1;
  logic        feed_en, first_pending;
  logic [63:0] first_word;
  int          word_mode;
  int          feed_limit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Kyber Parse on the byte stream: d1 = b0 + 256*(b1 mod 16), d2 = (b1>>4) + 16*b2.
  task automatic model_push(input logic [63:0] w);
    int b0, b1, b2;
    int d[2];
    for (int k = 0; k < 8; k++) m_bytes.push_back(w[8*k +: 8]);
    while (m_bytes.size() >= 3) begin
      b0 = m_bytes.pop_front();
      b1 = m_bytes.pop_front();
      b2 = m_bytes.pop_front();
      d[0] = b0 + 256 * (b1 % 16);
      d[1] = (b1 / 16) + 16 * b2;
      for (int j = 0; j < 2; j++) begin
        if (m_issued < N_COEF && d[j] < Q) begin
          exp_q.push_back({8'(m_issued), 12'(d[j])});
          m_issued++;
        end
      end
    end
  endtask

  function automatic logic [63:0] next_word();
    if (first_pending) begin
      first_pending = 1'b0;
      return first_word;
    end
    return (word_mode == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
  endfunction

  // ---------------- driver: one cycle ----------------
  // Called between a negedge and the next posedge: observes what the coming
  // edge will transfer, drives the keccak side, then waits one cycle.
  task automatic tick();
    logic [31:0] exp_pair;
    if (done) n_done++;
    if (coef_valid) seen_valid = 1'b1;
    if (gimme !== g_prev) n_gtog++;
    g_prev = gimme;
    if (coef_valid && coef_ready) begin
      exp_pair = (exp_q.size() != 0) ? {12'h0, exp_q.pop_front()} : 32'hFFFF_FFFF;
      if (n_hs == 0) cap0 = {coef_idx, coef};
      if (n_hs == 1) cap1 = {coef_idx, coef};
      check("coef_pair", {12'h0, coef_idx, coef}, exp_pair);
      n_hs++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (feed_en && gimme && n_words < feed_limit) begin
      in_valid = 1'b1;
      in_data  = next_word();
      n_words++;
      model_push(in_data);
    end
    @(negedge clk);
  endtask

  task automatic start_run();
    coef_ready = 1'b0;
    feed_en    = 1'b0;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    exp_q.delete();
    m_bytes.delete();
    m_issued   = 0;
    n_hs = 0; n_done = 0; n_words = 0; n_gtog = 0;
    seen_valid = 1'b0;
    g_prev     = gimme;
  endtask

  task automatic run_until_hs(input int n, input int budget, input string tag);
    int c = 0;
    while (n_hs < n && c < budget) begin
      tick();
      c++;
    end
    check(tag, 32'(n_hs >= n), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int c = 0;
    while (n_done == 0 && c < budget) begin
      tick();
      c++;
    end
    check(tag, 32'(n_done > 0), 32'd1);
    repeat (5) tick();
  endtask

  task automatic force_word(input logic [63:0] w, input logic expect_taken);
    in_valid = 1'b1;
    in_data  = w;
    if (expect_taken) model_push(w);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; coef_ready = 1'b0;
    feed_en = 1'b0; first_pending = 1'b0; first_word = '0; word_mode = 0;
    feed_limit = 1000; m_issued = 0; n_hs = 0; n_done = 0; n_words = 0; n_gtog = 0;
    seen_valid = 1'b0; g_prev = 1'b0; cap0 = '0; cap1 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_gimme", 32'(gimme), 32'd0);
    check("rst_coef", 32'(coef), 32'd0);
    check("rst_coef_idx", 32'(coef_idx), 32'd0);
    check("rst_coef_valid", 32'(coef_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
`ifdef KYBER_PARSE_REJECT_CNT_EN
    check("rst_reject_cnt", 32'(reject_cnt), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // All-zero words: 256 zeros in index order from 48 words, one done pulse.
    word_mode = 0; feed_limit = 1000;
    start_run();
    coef_ready = 1'b1; feed_en = 1'b1;
    wait_done(2000, "zero_done_seen");
    check("zero_hs_count", 32'(n_hs), 32'd256);
    check("zero_queue_empty", 32'(exp_q.size()), 32'd0);
    check("zero_done_pulses", 32'(n_done), 32'd1);
    // 48 words complete the polynomial; at most one more may already be in flight.
    check("zero_words_min", 32'(n_words >= 48), 32'd1);
    check("zero_words_max", 32'(n_words <= 49), 32'd1);
    check("zero_gimme_after", 32'(gimme), 32'd0);
    check("zero_state_idle", 32'(fsm_state), 32'd0);
    check("zero_valid_after", 32'(coef_valid), 32'd0);

    // Known vector, then a restart at coef_idx 100.
    first_word = 64'h0000_0000_0045_2301; first_pending = 1'b1;
    start_run();
    coef_ready = 1'b1; feed_en = 1'b1;
    run_until_hs(100, 1000, "vec_hs_wait");
    check("vec_coef0", 32'(cap0), {12'h0, 8'd0, 12'd769});
    check("vec_coef1", 32'(cap1), {12'h0, 8'd1, 12'd1106});
    check("vec_idx_at_restart", 32'(coef_idx), 32'd100);
    start_run();
    check("restart_valid_clear", 32'(coef_valid), 32'd0);
    check("restart_state_run", 32'(fsm_state), 32'd1);
    check("restart_gimme", 32'(gimme), 32'd1);
    coef_ready = 1'b1; feed_en = 1'b1;
    run_until_hs(3, 100, "restart_hs_wait");
    check("restart_first_idx", 32'(cap0[19:12]), 32'd0);

    // 3328 accepted, 3329 rejected.
    first_word = 64'h0000_0000_00D0_1D00; first_pending = 1'b1;
    start_run();
    coef_ready = 1'b1; feed_en = 1'b1;
    run_until_hs(5, 200, "bound_hs_wait");
    check("bound_coef0", 32'(cap0), {12'h0, 8'd0, 12'd3328});
    check("bound_coef1", 32'(cap1), {12'h0, 8'd1, 12'd0});
`ifdef KYBER_PARSE_REJECT_CNT_EN
    check("bound_reject_cnt", 32'(reject_cnt), 32'd1);
`endif

    // All-ones stream: every candidate is 4095 and rejected.
    word_mode = 1; feed_limit = 15;
    start_run();
    coef_ready = 1'b1; feed_en = 1'b1;
    repeat (120) tick();
    check("ones_words", 32'(n_words), 32'd15);
    check("ones_no_valid", 32'(seen_valid), 32'd0);
    check("ones_overflow", 32'(overflow), 32'd0);
    check("ones_gimme_toggles", 32'(n_gtog >= 4), 32'd1);
    check("ones_gimme_drained", 32'(gimme), 32'd1);
`ifdef KYBER_PARSE_REJECT_CNT_EN
    check("ones_reject_cnt", 32'(reject_cnt), 32'd80);
`endif

    // Backpressure, then overflow, then finish the polynomial.
    word_mode = 0; feed_limit = 1000;
    start_run();
    coef_ready = 1'b1; feed_en = 1'b1;
    run_until_hs(20, 200, "bp_hs_wait");
    coef_ready = 1'b0;
    check("bp_valid", 32'(coef_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid_hold", 32'(coef_valid), 32'd1);
      check("bp_pair_hold", {12'h0, coef_idx, coef},
            (exp_q.size() != 0) ? {12'h0, exp_q[0]} : 32'hFFFF_FFFF);
    end
    check("bp_gimme_low", 32'(gimme), 32'd0);
    feed_en = 1'b0;
    force_word(64'h0FED_CBA9_8765_4321, 1'b1);
    check("ovf_not_yet", 32'(overflow), 32'd0);
    force_word(64'h0123_4567_89AB_CDEF, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    coef_ready = 1'b1; feed_en = 1'b1;
    wait_done(2000, "ovf_done_seen");
    check("ovf_hs_count", 32'(n_hs), 32'd256);
    check("ovf_queue_empty", 32'(exp_q.size()), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    start_run();
    check("ovf_cleared", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
